// File: rtl/ex_muldiv_pkg.sv
// Shared encodings, state type and special-case constants for the RV32M
// multiply/divide unit.
package md_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_funct_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  localparam logic [XLEN-1:0] MD_DIV0_Q       = '1;
  localparam logic [XLEN-1:0] MD_OVF_DIVIDEND = 32'h8000_0000;

endpackage

// File: rtl/ex_muldiv_if.sv
// Execute-stage request/response bundle between the pipeline and ex_muldiv.
interface ex_muldiv_if;
  import md_pkg::*;

  // md_start is a level request held by the ID/EX register; the unit keeps
  // mult_stall high until the op completes, then md_result_valid stays high
  // while in DONE and drops one cycle after pipe_hold is released.
  logic            md_start;
  logic [2:0]      md_funct;
  logic [XLEN-1:0] md_op1;
  logic [XLEN-1:0] md_op2;
  logic            pipe_hold;
  logic            md_flush;
  logic            mult_stall;
  logic [XLEN-1:0] md_result;
  logic            md_result_valid;

  modport master (
    output md_start, md_funct, md_op1, md_op2, pipe_hold, md_flush,
    input  mult_stall, md_result, md_result_valid
  );

  modport slave (
    input  md_start, md_funct, md_op1, md_op2, pipe_hold, md_flush,
    output mult_stall, md_result, md_result_valid
  );

endinterface

// File: rtl/md_step.sv
// One iteration of radix-2 shift-add multiply or restoring shift-subtract
// divide over a shared 64-bit accumulator.
module md_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc_in,
  input  logic [XLEN-1:0]   opnd,
  output logic [2*XLEN-1:0] acc_out
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] trial;

  // Divide keeps {remainder, dividend->quotient}; multiply keeps {high, multiplier->low}.
  always_comb begin
    acc_out = '0;
    sum     = '0;
    rem_sh  = '0;
    trial   = '0;
    if (is_div) begin
      rem_sh = acc_in[2*XLEN-1:XLEN-1];
      trial  = rem_sh - {1'b0, opnd};
      if (trial[XLEN]) acc_out = {rem_sh[XLEN-1:0], acc_in[XLEN-2:0], 1'b0};
      else             acc_out = {trial[XLEN-1:0],  acc_in[XLEN-2:0], 1'b1};
    end else begin
      sum     = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, opnd} : '0);
      acc_out = {sum, acc_in[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M multiply/divide unit: latches operand magnitudes, iterates
// one bit per cycle, applies sign correction and holds the result in DONE.
module ex_muldiv #(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic              clk,
  input  logic              cpurst_n,
  ex_muldiv_if.slave        md,
  output md_pkg::md_state_t dbg_state
);
  import md_pkg::*;

  md_state_t         state, state_d;
  logic [4:0]        count;
  logic [2*XLEN-1:0] acc, acc_step, prod;
  logic [XLEN-1:0]   opnd, result_q, q_fix, r_fix, fin_res, early_res, a1, a2;
  logic [2:0]        funct_q;
  logic              neg_q, neg_in, start_op, stall;
  logic              s1, s2, op1_signed, op2_signed, div_zero, div_ovf, early;

  md_funct_t f;
  assign f = md_funct_t'(md.md_funct);

  always_comb begin
    op1_signed = (f == MD_MULH) || (f == MD_MULHSU) || (f == MD_DIV) || (f == MD_REM);
    op2_signed = (f == MD_MULH) || (f == MD_DIV) || (f == MD_REM);
    s1 = op1_signed & md.md_op1[XLEN-1];
    s2 = op2_signed & md.md_op2[XLEN-1];
    a1 = s1 ? (~md.md_op1 + 1'b1) : md.md_op1;
    a2 = s2 ? (~md.md_op2 + 1'b1) : md.md_op2;
    div_zero = (md.md_op2 == '0);
    div_ovf  = ((f == MD_DIV) || (f == MD_REM)) &&
               (md.md_op1 == MD_OVF_DIVIDEND) && (md.md_op2 == '1);
    // A zero divisor makes the quotient all-ones regardless of operand signs.
    case (f)
      MD_MULH:   neg_in = s1 ^ s2;
      MD_MULHSU: neg_in = s1;
      MD_DIV:    neg_in = (s1 ^ s2) & ~div_zero;
      MD_REM:    neg_in = s1;
      default:   neg_in = 1'b0;
    endcase
    early     = EARLY_OUT && f[2] && (div_zero || div_ovf);
    early_res = div_zero ? (f[1] ? md.md_op1 : MD_DIV0_Q)
                         : (f[1] ? '0 : MD_OVF_DIVIDEND);
  end

  md_step #(.XLEN(XLEN)) u_step (
    .is_div  (funct_q[2]),
    .acc_in  (acc),
    .opnd    (opnd),
    .acc_out (acc_step)
  );

  always_comb begin
    prod  = neg_q ? (~acc_step + 1'b1) : acc_step;
    q_fix = neg_q ? (~acc_step[XLEN-1:0] + 1'b1) : acc_step[XLEN-1:0];
    r_fix = neg_q ? (~acc_step[2*XLEN-1:XLEN] + 1'b1) : acc_step[2*XLEN-1:XLEN];
    case (md_funct_t'(funct_q))
      MD_MUL:                      fin_res = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fin_res = prod[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:             fin_res = q_fix;
      default:                     fin_res = r_fix;
    endcase
  end

  always_comb begin
    state_d  = state;
    start_op = 1'b0;
    stall    = 1'b0;
    case (state)
      MD_IDLE: begin
        if (md.md_start && !md.md_flush) begin
          stall    = 1'b1;
          start_op = 1'b1;
          state_d  = early ? MD_DONE : MD_BUSY;
        end
      end
      MD_BUSY: begin
        stall = 1'b1;
        if (md.md_flush)        state_d = MD_IDLE;
        else if (count == 5'd0) state_d = MD_DONE;
      end
      MD_DONE: begin
        if (md.md_flush || !md.pipe_hold) state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!cpurst_n) begin
      state    <= MD_IDLE;
      count    <= '0;
      acc      <= '0;
      opnd     <= '0;
      funct_q  <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state <= state_d;
      if (start_op) begin
        funct_q <= md.md_funct;
        neg_q   <= neg_in;
        count   <= 5'(XLEN - 1);
        opnd    <= f[2] ? a2 : a1;
        acc     <= {{XLEN{1'b0}}, (f[2] ? a1 : a2)};
        if (early) result_q <= early_res;
      end else if (state == MD_BUSY && !md.md_flush) begin
        acc <= acc_step;
        if (count != 5'd0) count    <= count - 5'd1;
        else               result_q <= fin_res;
      end
    end
  end

  assign md.mult_stall      = stall;
  assign md.md_result       = result_q;
  assign md.md_result_valid = (state == MD_DONE);
  assign dbg_state          = state;

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Multi-cycle RV32M multiply/divide unit in the execute stage.
- Consumes the MD-op fields held in the decode/execute pipeline register.
- Produces `mult_stall`, which freezes that register and the stages upstream while an operation is in flight.
- Returns a 32-bit result to the execute-stage writeback mux once the operation completes.

Parameters:
- XLEN, 32, operand/result width (only 32 supported)
- EARLY_OUT, 1, 1 = divide-by-zero and signed-overflow divides complete without iterating

Ports:
- clk  input  1  core clock
- cpurst_n  input  1  synchronous active-low reset
- md_start  input  1  MD op present in the execute stage (MD_OP_ffout & inst_valid_ffout)
- md_funct  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- md_op1  input  XLEN  rs1 operand
- md_op2  input  XLEN  rs2 operand
- pipe_hold  input  1  any other execute/memory stall (store-load conflict, mem_stall, readram_stall)
- md_flush  input  1  exception in writeback or interrupt; kills the op in flight
- mult_stall  output  1  hold decode/execute pipeline register
- md_result  output  XLEN  final result
- md_result_valid  output  1  md_result valid this cycle

Behaviour:
- Clocking: all state updates on the posedge of `clk`.
- Reset: `cpurst_n`=0 at an edge forces the following:
  - state=IDLE, count=0, md_result=0, md_result_valid=0.
  - Reset mid-operation abandons the op with no result.
- States: IDLE, BUSY, DONE.
- `mult_stall` is combinational: (IDLE & md_start & ~md_flush) | BUSY.
  - It is low in DONE.
  - It must assert in the same cycle `md_start` first rises, so the pipeline register holds operands stable.
- IDLE:
  - On md_start & ~md_flush, latch operands.
  - For signed variants, latch absolute values and record the result sign:
    - MULH: s1^s2.
    - MULHSU: s1.
    - DIV: s1^s2 (zero divisor excluded).
    - REM: s1.
  - Load count=XLEN-1 and go to BUSY.
  - With EARLY_OUT=1, special divides go straight to DONE with the result computed:
    - Divisor 0: DIV/DIVU give all-ones; REM/REMU give op1.
    - DIV/REM of 0x80000000 by 0xFFFFFFFF: DIV gives 0x80000000, REM gives 0.
- BUSY:
  - Multiply: one radix-2 shift-add step per cycle over a 64-bit accumulator.
  - Divide: one restoring shift-subtract step per cycle, producing a 32-bit quotient and a 32-bit remainder.
  - count decrements each cycle. At count==0, apply sign correction (two's complement of the 64-bit product / quotient / remainder as recorded), register md_result and go to DONE.
  - Result selection:
    - MUL takes the low 32 bits.
    - MULH/MULHSU/MULHU take the high 32 bits.
    - DIV/DIVU take the quotient.
    - REM/REMU take the remainder.
- Latency: the normal path has `mult_stall` high for 1+XLEN = 33 cycles, and md_result_valid=1 in the 34th cycle. The early-out path has stall high for 1 cycle, with valid in the 2nd.
- DONE:
  - md_result_valid=1 and md_result held.
  - If pipe_hold=1, stay in DONE; this guards against re-starting the same instruction, which is still present because the register is held.
  - If pipe_hold=0, go to IDLE and drop md_result_valid next cycle. md_result keeps its value until the next completion.
- Flush: md_flush in any state forces IDLE next cycle with md_result_valid=0.
  - Flush has priority over start and completion.
  - mult_stall=0 while md_flush=1 in IDLE.
- Back-to-back: DONE→IDLE; a new md_start in IDLE starts immediately. Minimum gap between results is 1 idle cycle.
- md_funct/md_op1/md_op2 are ignored outside IDLE; operands are internal copies.

Decomposition:
- Shared package `md_pkg`:
  - md_funct encodings (MD_MUL..MD_REMU).
  - state enum (MD_IDLE, MD_BUSY, MD_DONE).
  - XLEN constant.
  - Special-case constants: MD_DIV0_Q = all-ones, MD_OVF_DIVIDEND = 0x80000000.
- One natural sub-module, `md_step`: combinational single iteration (shift-add for multiply, shift-subtract/restore for divide) selected by an is_div flag. The FSM, counter and sign logic stay in `ex_muldiv`.

Test Plan:
- MUL, op1=7, op2=-3 (0xFFFFFFFD) → stall 33 cycles, then result 0xFFFFFFEB, valid 1 cycle with pipe_hold=0.
- MULHU, 0xFFFFFFFF × 0xFFFFFFFF → result 0xFFFFFFFE. MULH same operands → 0x00000000. MULHSU with op1=-1, op2=2 → 0xFFFFFFFF.
- Division cases:
  - DIV -20/3 → 0xFFFFFFFA.
  - REM -20/3 → 0xFFFFFFFE.
  - DIVU 100/0 → 0xFFFFFFFF with stall 1 cycle.
  - REM 0x80000000/0xFFFFFFFF → 0 with stall 1 cycle.
- Completion held: DIVU 10/3 with pipe_hold=1 for 3 cycles at completion → DONE held, valid stays 1, result 3, no restart. Release → IDLE.
- Flush at BUSY cycle 10 of MUL 5×5 → IDLE next cycle, mult_stall drops, no valid. A subsequent MUL 6×6 → 36.
- cpurst_n=0 during BUSY → next cycle mult_stall=0, md_result=0, valid=0. md_start held with reset released → new op restarts from IDLE.
